// File: rtl/get_length_seq.sv
// Multi-cycle bit-position unit: scans the latched operand CHUNK bits per cycle
// and reports bit-length, leading zeros, trailing zeros or population count.
// Modes 00/01 scan MSB-first, modes 10/11 scan LSB-first; the scan stops at the
// first chunk that decides the answer (popcount always visits every chunk).
module get_length_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             md_start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] num_in,
    output logic [LEN_W-1:0] len_out,
    output logic             zero_out,
    output logic             busy,
    output logic             md_end
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IDX_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic [1:0]         mode_q,    mode_d;
    logic [PTR_W-1:0]   ptr_q,     ptr_d;
    logic [LEN_W-1:0]   acc_q,     acc_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic               zero_q,    zero_d;
    logic               busy_q,    busy_d;
    logic               mdEnd_q,   mdEnd_d;

    logic [CHUNK-1:0]   curChunk;
    logic [IDX_W-1:0]   hiIdx;
    logic [IDX_W-1:0]   loIdx;
    logic [LEN_W-1:0]   chunkPop;
    logic [LEN_W-1:0]   hiPos;
    logic [LEN_W-1:0]   loPos;
    logic [LEN_W-1:0]   popTotal;
    logic               chunkNz;
    logic               lastChunk;
    logic               scanDone;
    logic [LEN_W-1:0]   scanResult;
    logic               scanZero;

    // Decode the chunk under the pointer: highest/lowest set bit and its popcount.
    always_comb begin
        curChunk = operand_q[ptr_q*CHUNK +: CHUNK];
        hiIdx    = '0;
        loIdx    = '0;
        chunkPop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (curChunk[i]) begin
                hiIdx    = IDX_W'(i);
                chunkPop = chunkPop + LEN_W'(1);
            end
        end
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (curChunk[i]) begin
                loIdx = IDX_W'(i);
            end
        end
        chunkNz   = |curChunk;
        hiPos     = LEN_W'(ptr_q) * LEN_W'(CHUNK) + LEN_W'(hiIdx);
        loPos     = LEN_W'(ptr_q) * LEN_W'(CHUNK) + LEN_W'(loIdx);
        popTotal  = acc_q + chunkPop;
        lastChunk = mode_q[1] ? (ptr_q == PTR_W'(NCH - 1)) : (ptr_q == '0);
    end

    // Decide whether this scan cycle finishes the request and what it reports.
    always_comb begin
        scanDone   = 1'b0;
        scanResult = '0;
        scanZero   = 1'b0;
        case (mode_q)
            2'b00, 2'b01: begin
                if (chunkNz) begin
                    scanDone   = 1'b1;
                    scanResult = mode_q[0] ? (LEN_W'(WIDTH - 1) - hiPos) : (hiPos + LEN_W'(1));
                end else if (lastChunk) begin
                    scanDone   = 1'b1;
                    scanResult = mode_q[0] ? LEN_W'(WIDTH) : '0;
                    scanZero   = 1'b1;
                end
            end
            2'b10: begin
                if (chunkNz) begin
                    scanDone   = 1'b1;
                    scanResult = loPos;
                end else if (lastChunk) begin
                    scanDone   = 1'b1;
                    scanResult = LEN_W'(WIDTH);
                    scanZero   = 1'b1;
                end
            end
            default: begin
                if (lastChunk) begin
                    scanDone   = 1'b1;
                    scanResult = popTotal;
                    scanZero   = (popTotal == '0);
                end
            end
        endcase
    end

    // Next-state logic: accept requests in IDLE, walk the chunks in SCAN.
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        mode_d    = mode_q;
        ptr_d     = ptr_q;
        acc_d     = acc_q;
        len_d     = len_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        mdEnd_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    operand_d = num_in;
                    mode_d    = mode;
                    ptr_d     = mode[1] ? '0 : PTR_W'(NCH - 1);
                    acc_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                acc_d = popTotal;
                if (scanDone) begin
                    len_d   = scanResult;
                    zero_d  = scanZero;
                    mdEnd_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    ptr_d = mode_q[1] ? (ptr_q + PTR_W'(1)) : (ptr_q - PTR_W'(1));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset that also aborts a scan.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            operand_q <= '0;
            mode_q    <= '0;
            ptr_q     <= '0;
            acc_q     <= '0;
            len_q     <= '0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            mdEnd_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            mode_q    <= mode_d;
            ptr_q     <= ptr_d;
            acc_q     <= acc_d;
            len_q     <= len_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            mdEnd_q   <= mdEnd_d;
        end
    end

    assign len_out  = len_q;
    assign zero_out = zero_q;
    assign busy     = busy_q;
    assign md_end   = mdEnd_q;

endmodule

// File: tb/tb_get_length_seq.sv
// Self-checking bench for get_length_seq: directed scenarios plus randomized
// requests compared against a whole-word reference model.
module tb_get_length_seq;

    localparam int WIDTH = 64;
    localparam int CHUNK = 8;
    localparam int NCH   = WIDTH / CHUNK;
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             md_start = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] num_in = '0;
    logic [LEN_W-1:0] len_out;
    logic             zero_out;
    logic             busy;
    logic             md_end;

    int total = 0;
    int bad   = 0;

    get_length_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .md_start (md_start),
        .mode     (mode),
        .num_in   (num_in),
        .len_out  (len_out),
        .zero_out (zero_out),
        .busy     (busy),
        .md_end   (md_end)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference: evaluate the metric over the whole word, then derive how many
    // chunks a scan in the metric's direction must visit.
    function automatic void refModel(input logic [1:0] m, input logic [WIDTH-1:0] n,
                                     output int res, output bit z, output int lat);
        int msb = -1;
        int lsb = -1;
        int pop = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (n[i]) begin
                msb = i;
                pop++;
                if (lsb < 0) lsb = i;
            end
        end
        z = (n == '0);
        case (m)
            2'b00:   res = msb + 1;
            2'b01:   res = WIDTH - 1 - msb;
            2'b10:   res = z ? WIDTH : lsb;
            default: res = pop;
        endcase
        if (m == 2'b11 || z) lat = NCH;
        else if (m == 2'b10) lat = lsb / CHUNK + 1;
        else lat = NCH - msb / CHUNK;
    endfunction

    // Issue one request from just after a clock edge and wait for md_end.
    // lat = cycles from the accepting edge to md_end (-1 on timeout).
    task automatic doRequest(input logic [1:0] m, input logic [WIDTH-1:0] n,
                             output int lat, output int busyCnt);
        mode     = m;
        num_in   = n;
        md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        lat      = -1;
        busyCnt  = 0;
        if (busy) busyCnt++;
        for (int c = 1; c <= NCH + 4; c++) begin
            @(posedge clk); #1;
            if (md_end) begin
                lat = c;
                break;
            end
            if (busy) busyCnt++;
        end
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        md_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (len_out !== '0) begin bad++; $display("[TB] FAIL reset_len actual=%0d expected=0", len_out); end
        total++; if (zero_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_zero actual=%0b expected=0", zero_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy actual=%0b expected=0", busy); end
        total++; if (md_end !== 1'b0) begin bad++; $display("[TB] FAIL reset_mdend actual=%0b expected=0", md_end); end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_length();
        int lat, bc;
        doRequest(2'b00, 64'h9, lat, bc);
        total++; if (lat !== 8) begin bad++; $display("[TB] FAIL len9_latency actual=%0d expected=8", lat); end
        total++; if (len_out !== LEN_W'(4)) begin bad++; $display("[TB] FAIL len9_result actual=%0d expected=4", len_out); end
        total++; if (zero_out !== 1'b0) begin bad++; $display("[TB] FAIL len9_zero actual=%0b expected=0", zero_out); end
        total++; if (bc !== 8) begin bad++; $display("[TB] FAIL len9_busy_cycles actual=%0d expected=8", bc); end
        @(posedge clk); #1;
        total++; if (md_end !== 1'b0) begin bad++; $display("[TB] FAIL len9_pulse_width actual=%0b expected=0", md_end); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        doRequest(2'b00, 64'h8000_0000_0000_0000, lat, bc);
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL b2b_first_latency actual=%0d expected=1", lat); end
        total++; if (len_out !== LEN_W'(64)) begin bad++; $display("[TB] FAIL b2b_first_result actual=%0d expected=64", len_out); end
        doRequest(2'b01, 64'h00FF_0000_0000_0000, lat, bc);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL b2b_second_latency actual=%0d expected=2", lat); end
        total++; if (len_out !== LEN_W'(8)) begin bad++; $display("[TB] FAIL b2b_second_result actual=%0d expected=8", len_out); end
    endtask

    task automatic test_trail_pop();
        int lat, bc;
        doRequest(2'b10, 64'h100, lat, bc);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL tz_latency actual=%0d expected=2", lat); end
        total++; if (len_out !== LEN_W'(8)) begin bad++; $display("[TB] FAIL tz_result actual=%0d expected=8", len_out); end
        doRequest(2'b11, '1, lat, bc);
        total++; if (lat !== 8) begin bad++; $display("[TB] FAIL pop_latency actual=%0d expected=8", lat); end
        total++; if (len_out !== LEN_W'(64)) begin bad++; $display("[TB] FAIL pop_result actual=%0d expected=64", len_out); end
        total++; if (zero_out !== 1'b0) begin bad++; $display("[TB] FAIL pop_zero actual=%0b expected=0", zero_out); end
    endtask

    task automatic test_zero_operand();
        int lat, bc;
        int expLen[4] = '{0, 64, 64, 0};
        for (int m = 0; m < 4; m++) begin
            doRequest(2'(m), '0, lat, bc);
            total++; if (lat !== 8) begin bad++; $display("[TB] FAIL zero_latency mode=%0d actual=%0d expected=8", m, lat); end
            total++; if (len_out !== LEN_W'(expLen[m])) begin bad++; $display("[TB] FAIL zero_result mode=%0d actual=%0d expected=%0d", m, len_out, expLen[m]); end
            total++; if (zero_out !== 1'b1) begin bad++; $display("[TB] FAIL zero_flag mode=%0d actual=%0b expected=1", m, zero_out); end
        end
    endtask

    task automatic test_ignore_busy();
        int lat = -1;
        int extra = 0;
        mode     = 2'b00;
        num_in   = 64'h1;
        md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        for (int c = 1; c <= NCH + 4; c++) begin
            @(posedge clk); #1;
            if (md_end) begin
                lat = c;
                break;
            end
            if (c == 2) begin
                md_start = 1'b1;
                mode     = 2'b11;
                num_in   = '1;
            end
            if (c == 3) begin
                md_start = 1'b0;
                num_in   = 64'hF0F0_0000_0000_0000;
            end
        end
        md_start = 1'b0;
        total++; if (lat !== 8) begin bad++; $display("[TB] FAIL busy_ignore_latency actual=%0d expected=8", lat); end
        total++; if (len_out !== LEN_W'(1)) begin bad++; $display("[TB] FAIL busy_ignore_result actual=%0d expected=1", len_out); end
        for (int c = 0; c < NCH + 2; c++) begin
            @(posedge clk); #1;
            if (md_end || busy) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("[TB] FAIL busy_ignore_no_queue actual=%0d expected=0", extra); end
    endtask

    task automatic test_abort();
        int lat, bc, res, expLat;
        bit z;
        int seen = 0;
        mode     = 2'b11;
        num_in   = 64'h0123_4567_89AB_CDEF;
        md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy actual=%0b expected=0", busy); end
        total++; if (md_end !== 1'b0) begin bad++; $display("[TB] FAIL abort_mdend actual=%0b expected=0", md_end); end
        total++; if (len_out !== '0) begin bad++; $display("[TB] FAIL abort_len actual=%0d expected=0", len_out); end
        total++; if (zero_out !== 1'b0) begin bad++; $display("[TB] FAIL abort_zero actual=%0b expected=0", zero_out); end
        rstn = 1'b1;
        for (int c = 0; c < NCH + 4; c++) begin
            @(posedge clk); #1;
            if (md_end) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("[TB] FAIL abort_late_mdend actual=%0d expected=0", seen); end
        refModel(2'b10, 64'h8000_0000, res, z, expLat);
        doRequest(2'b10, 64'h8000_0000, lat, bc);
        total++; if (lat !== expLat) begin bad++; $display("[TB] FAIL abort_fresh_latency actual=%0d expected=%0d", lat, expLat); end
        total++; if (len_out !== LEN_W'(res)) begin bad++; $display("[TB] FAIL abort_fresh_result actual=%0d expected=%0d", len_out, res); end
    endtask

    task automatic test_random();
        int lat, bc, res, expLat;
        bit z;
        logic [WIDTH-1:0] r;
        logic [1:0] m;
        for (int k = 0; k < 60; k++) begin
            r = {$urandom, $urandom};
            r = r >> $urandom_range(0, 64);
            r = r << $urandom_range(0, 63);
            if ($urandom_range(0, 9) == 0) r = '0;
            m = 2'($urandom_range(0, 3));
            refModel(m, r, res, z, expLat);
            doRequest(m, r, lat, bc);
            total++; if (lat !== expLat) begin bad++; $display("[TB] FAIL rand_latency mode=%0d num=%h actual=%0d expected=%0d", m, r, lat, expLat); end
            total++; if (len_out !== LEN_W'(res)) begin bad++; $display("[TB] FAIL rand_result mode=%0d num=%h actual=%0d expected=%0d", m, r, len_out, res); end
            total++; if (zero_out !== z) begin bad++; $display("[TB] FAIL rand_zero mode=%0d num=%h actual=%0b expected=%0b", m, r, zero_out, z); end
            total++; if (bc !== expLat) begin bad++; $display("[TB] FAIL rand_busy_cycles mode=%0d num=%h actual=%0d expected=%0d", m, r, bc, expLat); end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_length();
        test_back_to_back();
        test_trail_pop();
        test_zero_operand();
        test_ignore_busy();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/get_length_seq.md
Name: get_length_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle bit-length unit.
- Scans a WIDTH-bit operand CHUNK bits per cycle and returns one of four bit-position metrics: bit-length, leading-zero count, trailing-zero count, or population count.
- Stops early once the answer is known.
- Uses the team's md_start/md_end handshake, plus a busy flag, so arithmetic datapath controllers can issue back-to-back requests.

Parameters:
- WIDTH, 64, operand width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits examined per SCAN cycle. Must be a power of 2 and ≤ WIDTH.
- LEN_W, $clog2(WIDTH+1), result width. Holds 0..WIDTH inclusive.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- md_start  in  1  request strobe. Sampled only in IDLE.
- mode  in  2  metric select, latched with md_start: 00 length (MSB index + 1), 01 leading zeros, 10 trailing zeros, 11 popcount.
- num_in  in  WIDTH  operand, latched with md_start.
- len_out  out  LEN_W  result. Held until the next result is written.
- zero_out  out  1  high when the latched operand was all zeros. Updated together with len_out.
- busy  out  1  high while a request is in progress.
- md_end  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rstn=0 at an edge): state=IDLE; len_out=0, zero_out=0, busy=0, md_end=0; internal operand, mode and chunk counter cleared.
  - Applies mid-SCAN too: the request is aborted and no md_end is produced.
- FSM states: IDLE, SCAN. NCH = WIDTH/CHUNK chunks, indexed 0 (LSBs) .. NCH-1 (MSBs).
- IDLE:
  - md_end defaults to 0 every cycle unless set by SCAN completion.
  - md_start=1 at edge E0: latch num_in and mode, set busy=1, go to SCAN.
  - Chunk pointer starts at NCH-1 for modes 00/01 (MSB-first) and at 0 for modes 10/11 (LSB-first).
  - md_start=0: stay in IDLE; outputs hold.
- SCAN, one chunk per edge:
  - Modes 00/01: the first nonzero chunk, scanning downward, terminates the scan. Bit position p = chunk*CHUNK + index of the highest set bit in the chunk. Result is p+1 (mode 00) or WIDTH-1-p (mode 01).
  - Mode 10: the first nonzero chunk, scanning upward, terminates. p = chunk*CHUNK + index of the lowest set bit. Result is p.
  - Mode 11: accumulates the popcount of every chunk; never terminates early; runs all NCH cycles.
  - All-zero operand: the scan reaches the last chunk. Results: mode 00 → 0, 01 → WIDTH, 10 → WIDTH, 11 → 0. zero_out=1.
  - Terminating edge: len_out and zero_out are written, md_end<=1, busy<=0, state→IDLE.
  - Non-terminating edge: advance the pointer and hold the outputs.
- Latency:
  - md_end is high exactly k cycles after E0, where k = number of chunks examined (1..NCH).
  - Mode 11 and all-zero operands always take NCH cycles.
- md_start while busy=1 is ignored: no queueing, and the latched operand and mode are unaffected.
- md_start during the md_end cycle (state IDLE) is accepted, so back-to-back throughput is one request per k+1 cycles.
- num_in and mode changes after E0 have no effect on an in-flight request.
- Arithmetic:
  - All counts are unsigned LEN_W bits; there is no overflow because the maximum result is WIDTH.
  - Pointer wrap cannot occur because the scan ends at chunk 0 (downward) or NCH-1 (upward).
- len_out and zero_out change only on a terminating edge or on reset.

Test Plan:
- WIDTH=64, CHUNK=8, mode 00, num_in=0x9 → 8 cycles after E0: md_end pulses for 1 cycle, len_out=4, zero_out=0; busy high for 8 cycles.
- mode 00, num_in=0x8000_0000_0000_0000 → md_end 1 cycle after E0, len_out=64. Immediately follow with mode 01, num_in=0x00FF_0000_0000_0000 issued in the md_end cycle → accepted; md_end 2 cycles later, len_out=8.
- mode 10, num_in=0x100 → md_end after 2 cycles, len_out=8. Mode 11, num_in=0xFFFF_FFFF_FFFF_FFFF → md_end after 8 cycles, len_out=64.
- num_in=0 in each mode → md_end after 8 cycles; len_out = 0/64/64/0 for modes 00/01/10/11; zero_out=1.
- Start mode 00 with num_in=0x1. Pulse md_start with num_in=0xFFFF..., and change num_in, during busy → ignored; md_end after 8 cycles, len_out=1.
- Start mode 11, drive rstn=0 on cycle 4 of SCAN → next cycle busy=0, md_end=0, len_out=0, zero_out=0. No md_end is seen afterwards, and a fresh request completes normally.
